// File: rtl/siw_memory_pkg.sv
// Shared constants for the parametrised dual-port BRAM wrapper: default geometry,
// mem_conf encodings and the delay-tap selection helper.
package siw_memory_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_MAX_DLY = 3;
  localparam int MEM_CONF_W  = 2;

  typedef enum logic [MEM_CONF_W-1:0] {
    CONF_NODLY = 2'd0,
    CONF_DLY1  = 2'd1,
    CONF_DLY2  = 2'd2,
    CONF_DLY3  = 2'd3
  } mem_conf_e;

  // Returns 0 for the undelayed path, otherwise the stage index clamped to max_dly.
  function automatic int conf_tap(input int conf, input int max_dly);
    if (conf == int'(CONF_NODLY)) return 0;
    if (conf > max_dly) return max_dly;
    return conf;
  endfunction

endpackage

// File: rtl/siw_tp_mem_2r2w.sv
// Generic true dual-port RAM, one clock, read-first on both ports.
// Write arbitration between ports is the caller's job.
module siw_tp_mem_2r2w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Reads sample the array before this edge's writes land, giving read-first
  // behaviour on the same port and old data on the opposite port.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= wdata_b;
    if (we_a) mem[addr_a] <= wdata_a;
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/siw_memory_bram_param.sv
// Parametrised dual-port BRAM wrapper with per-port write-enable delay lines.
// Optional macro SIW_MEMORY_BRAM_PARAM_COLLISION_EN enables the sticky collision flag.
module siw_memory_bram_param
  import siw_memory_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAX_DLY = DEF_MAX_DLY,
  parameter int CONF_W  = MEM_CONF_W
) (
  input  logic              siw_memory_bram_param_clk,
  input  logic              siw_memory_bram_param_reset_n,
  input  logic              siw_memory_bram_param_init,
  input  logic              siw_memory_bram_param_mem_sel,
  input  logic              siw_memory_bram_param_enable_a,
  input  logic              siw_memory_bram_param_enable_b,
  input  logic              siw_memory_bram_param_write_en_a,
  input  logic              siw_memory_bram_param_write_en_b,
  input  logic [ADDR_W-1:0] siw_memory_bram_param_address_a,
  input  logic [ADDR_W-1:0] siw_memory_bram_param_address_b,
  input  logic [DATA_W-1:0] siw_memory_bram_param_input_data_a,
  input  logic [DATA_W-1:0] siw_memory_bram_param_input_data_b,
  input  logic [CONF_W-1:0] siw_memory_bram_param_mem_conf_a,
  input  logic [CONF_W-1:0] siw_memory_bram_param_mem_conf_b,
  output logic [DATA_W-1:0] siw_memory_bram_param_output_data_a,
  output logic [DATA_W-1:0] siw_memory_bram_param_output_data_b,
  output logic              siw_memory_bram_param_collision
);

  logic              clk;
  logic              rst_n;
  logic [MAX_DLY:1]  dly_a;
  logic [MAX_DLY:1]  dly_b;
  logic              wr_a;
  logic              wr_b;
  logic              commit_a;
  logic              commit_b;
  logic              dual_hit;
  logic              we_b_arb;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [DATA_W-1:0] out_a_reg;
  logic [DATA_W-1:0] out_b_reg;

  assign clk   = siw_memory_bram_param_clk;
  assign rst_n = siw_memory_bram_param_reset_n;

  function automatic logic pick_tap(input logic raw, input logic [MAX_DLY:1] line,
                                    input logic [CONF_W-1:0] conf);
    logic r;
    int   sel;
    sel = conf_tap(int'(conf), MAX_DLY);
    r   = raw;
    for (int k = 1; k <= MAX_DLY; k++) begin
      if (sel == k) r = line[k];
    end
    return r;
  endfunction

  // init wins over shifting so an in-flight request can be cancelled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_a <= '0;
      dly_b <= '0;
    end else if (siw_memory_bram_param_init) begin
      dly_a <= '0;
      dly_b <= '0;
    end else begin
      dly_a[1] <= siw_memory_bram_param_write_en_a;
      dly_b[1] <= siw_memory_bram_param_write_en_b;
      for (int k = 2; k <= MAX_DLY; k++) begin
        dly_a[k] <= dly_a[k-1];
        dly_b[k] <= dly_b[k-1];
      end
    end
  end

  assign wr_a = pick_tap(siw_memory_bram_param_write_en_a, dly_a, siw_memory_bram_param_mem_conf_a);
  assign wr_b = pick_tap(siw_memory_bram_param_write_en_b, dly_b, siw_memory_bram_param_mem_conf_b);

  assign commit_a = wr_a & (siw_memory_bram_param_enable_a | siw_memory_bram_param_mem_sel);
  assign commit_b = wr_b & siw_memory_bram_param_enable_b;

  // Port A has priority on a same-address dual commit; B's write is dropped.
  assign dual_hit = commit_a & commit_b &
                    (siw_memory_bram_param_address_a == siw_memory_bram_param_address_b);
  assign we_b_arb = commit_b & ~dual_hit;

  siw_tp_mem_2r2w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_a    (commit_a),
    .addr_a  (siw_memory_bram_param_address_a),
    .wdata_a (siw_memory_bram_param_input_data_a),
    .we_b    (we_b_arb),
    .addr_b  (siw_memory_bram_param_address_b),
    .wdata_b (siw_memory_bram_param_input_data_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a_reg <= '0;
      out_b_reg <= '0;
    end else begin
      out_a_reg <= rdata_a;
      out_b_reg <= rdata_b;
    end
  end

  assign siw_memory_bram_param_output_data_a = out_a_reg;
  assign siw_memory_bram_param_output_data_b = out_b_reg;

`ifdef SIW_MEMORY_BRAM_PARAM_COLLISION_EN
  logic coll_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_reg <= 1'b0;
    end else if (siw_memory_bram_param_init) begin
      coll_reg <= 1'b0;
    end else if (dual_hit) begin
      coll_reg <= 1'b1;
    end
  end

  assign siw_memory_bram_param_collision = coll_reg;
`else
  assign siw_memory_bram_param_collision = 1'b0;
`endif

endmodule

// File: tb/tb_siw_memory_bram_param.sv
// Directed bench for siw_memory_bram_param: a MAX_DLY=3 instance plus a MAX_DLY=2
// instance sharing the same stimulus to exercise delay-tap saturation.
module tb_siw_memory_bram_param;

`ifdef SIW_MEMORY_BRAM_PARAM_COLLISION_EN
  localparam logic COLL_ON = 1'b1;
`else
  localparam logic COLL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init;
  logic        mem_sel;
  logic        en_a, en_b, we_a, we_b;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;
  logic [1:0]  conf_a, conf_b;
  logic [31:0] dout_a, dout_b, dout2_a, dout2_b;
  logic        coll, coll2;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ra, rb, ra2;

  always #5 clk = ~clk;

  siw_memory_bram_param #(.DATA_W(32), .ADDR_W(10), .MAX_DLY(3), .CONF_W(2)) dut (
    .siw_memory_bram_param_clk          (clk),
    .siw_memory_bram_param_reset_n      (rst_n),
    .siw_memory_bram_param_init         (init),
    .siw_memory_bram_param_mem_sel      (mem_sel),
    .siw_memory_bram_param_enable_a     (en_a),
    .siw_memory_bram_param_enable_b     (en_b),
    .siw_memory_bram_param_write_en_a   (we_a),
    .siw_memory_bram_param_write_en_b   (we_b),
    .siw_memory_bram_param_address_a    (addr_a),
    .siw_memory_bram_param_address_b    (addr_b),
    .siw_memory_bram_param_input_data_a (din_a),
    .siw_memory_bram_param_input_data_b (din_b),
    .siw_memory_bram_param_mem_conf_a   (conf_a),
    .siw_memory_bram_param_mem_conf_b   (conf_b),
    .siw_memory_bram_param_output_data_a(dout_a),
    .siw_memory_bram_param_output_data_b(dout_b),
    .siw_memory_bram_param_collision    (coll)
  );

  siw_memory_bram_param #(.DATA_W(32), .ADDR_W(10), .MAX_DLY(2), .CONF_W(2)) dut2 (
    .siw_memory_bram_param_clk          (clk),
    .siw_memory_bram_param_reset_n      (rst_n),
    .siw_memory_bram_param_init         (init),
    .siw_memory_bram_param_mem_sel      (mem_sel),
    .siw_memory_bram_param_enable_a     (en_a),
    .siw_memory_bram_param_enable_b     (en_b),
    .siw_memory_bram_param_write_en_a   (we_a),
    .siw_memory_bram_param_write_en_b   (we_b),
    .siw_memory_bram_param_address_a    (addr_a),
    .siw_memory_bram_param_address_b    (addr_b),
    .siw_memory_bram_param_input_data_a (din_a),
    .siw_memory_bram_param_input_data_b (din_b),
    .siw_memory_bram_param_mem_conf_a   (conf_a),
    .siw_memory_bram_param_mem_conf_b   (conf_b),
    .siw_memory_bram_param_output_data_a(dout2_a),
    .siw_memory_bram_param_output_data_b(dout2_b),
    .siw_memory_bram_param_collision    (coll2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_b(input logic [9:0] a, input logic [31:0] d);
    en_b   = 1'b1;
    we_b   = 1'b1;
    addr_b = a;
    din_b  = d;
    tick();
    en_b = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] oa, output logic [31:0] ob,
                    output logic [31:0] oa2);
    addr_a = a;
    addr_b = a;
    tick();
    tick();
    oa  = dout_a;
    ob  = dout_b;
    oa2 = dout2_a;
  endtask

  initial begin
    // Reset with junk on every input
    rst_n = 1'b0; init = 1'b0; mem_sel = 1'b1;
    en_a = 1'b1; en_b = 1'b1; we_a = 1'b1; we_b = 1'b1;
    addr_a = 10'h2A5; addr_b = 10'h15A; din_a = 32'h1357_9BDF; din_b = 32'h2468_ACE0;
    conf_a = 2'd1; conf_b = 2'd2;
    #22;
    chk("rst_out_a", dout_a, 32'h0);
    chk("rst_out_b", dout_b, 32'h0);
    chk("rst_coll", {31'b0, coll}, 32'h0);
    chk("rst_out2_a", dout2_a, 32'h0);

    mem_sel = 1'b0; en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0; conf_a = 2'd0; conf_b = 2'd0;
    tick();
    rst_n = 1'b1;
    tick();

    // Two-cycle read latency, back-to-back addresses
    wr_b(10'd5, 32'hCAFE_0005);
    wr_b(10'd6, 32'hCAFE_0006);
    addr_a = 10'd5;
    tick();
    addr_a = 10'd6;
    tick();
    chk("lat_addr5", dout_a, 32'hCAFE_0005);
    tick();
    chk("lat_addr6", dout_a, 32'hCAFE_0006);

    // Undelayed port A write, then same-port read-during-write is read-first
    en_a = 1'b1; we_a = 1'b1; addr_a = 10'h010; din_a = 32'hDEAD_BEEF;
    tick();
    en_a = 1'b0; we_a = 1'b0;
    rd(10'h010, ra, rb, ra2);
    chk("conf0_wr", ra, 32'hDEAD_BEEF);
    en_a = 1'b1; we_a = 1'b1; din_a = 32'h0BAD_F00D;
    tick();
    en_a = 1'b0; we_a = 1'b0;
    tick();
    chk("rdw_old", dout_a, 32'hDEAD_BEEF);
    rd(10'h010, ra, rb, ra2);
    chk("rdw_new", ra, 32'h0BAD_F00D);

    // conf=2: commit lands only in cycle T+2
    wr_b(10'h020, 32'h0000_0020);
    wr_b(10'h021, 32'h0000_0021);
    wr_b(10'h022, 32'h0000_0022);
    wr_b(10'h024, 32'h0000_0024);
    conf_a = 2'd2; en_a = 1'b1;
    we_a = 1'b1; addr_a = 10'h024; din_a = 32'h99; tick();
    we_a = 1'b0; addr_a = 10'h021; din_a = 32'h5555; tick();
    addr_a = 10'h020; din_a = 32'h1234; tick();
    addr_a = 10'h022; din_a = 32'h6666; tick();
    en_a = 1'b0; conf_a = 2'd0;
    rd(10'h020, ra, rb, ra2); chk("c2_t2", ra, 32'h1234);
    rd(10'h021, ra, rb, ra2); chk("c2_t1", ra, 32'h21);
    rd(10'h022, ra, rb, ra2); chk("c2_t3", ra, 32'h22);
    rd(10'h024, ra, rb, ra2); chk("c2_t0", ra, 32'h24);

    // conf=3: T+3 on MAX_DLY=3, saturates to T+2 on MAX_DLY=2
    wr_b(10'h031, 32'h31);
    wr_b(10'h032, 32'h32);
    wr_b(10'h033, 32'h33);
    wr_b(10'h034, 32'h34);
    conf_a = 2'd3; en_a = 1'b1;
    we_a = 1'b1; addr_a = 10'h034; din_a = 32'hAA4; tick();
    we_a = 1'b0; addr_a = 10'h031; din_a = 32'hAA1; tick();
    addr_a = 10'h032; din_a = 32'hAA2; tick();
    addr_a = 10'h033; din_a = 32'hAA3; tick();
    en_a = 1'b0; conf_a = 2'd0;
    rd(10'h031, ra, rb, ra2); chk("c3_t1", ra, 32'h31); chk("sat_t1", ra2, 32'h31);
    rd(10'h032, ra, rb, ra2); chk("c3_t2", ra, 32'h32); chk("sat_t2", ra2, 32'hAA2);
    rd(10'h033, ra, rb, ra2); chk("c3_t3", ra, 32'hAA3); chk("sat_t3", ra2, 32'h33);
    rd(10'h034, ra, rb, ra2); chk("c3_t0", ra, 32'h34);

    // init one cycle after a conf=3 request cancels it
    wr_b(10'h040, 32'h40);
    conf_a = 2'd3; en_a = 1'b1; addr_a = 10'h040; din_a = 32'hBAD;
    we_a = 1'b1; tick();
    we_a = 1'b0; init = 1'b1; tick();
    init = 1'b0; tick();
    tick();
    tick();
    en_a = 1'b0; conf_a = 2'd0;
    rd(10'h040, ra, rb, ra2);
    chk("init_cancel", ra, 32'h40);
    chk("init_cancel2", ra2, 32'h40);

    // Dual commit to different addresses: both land, no collision
    chk("coll_pre", {31'b0, coll}, 32'h0);
    en_a = 1'b1; en_b = 1'b1; we_a = 1'b1; we_b = 1'b1;
    addr_a = 10'h100; din_a = 32'h1001; addr_b = 10'h101; din_b = 32'h2002;
    tick();
    en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    chk("coll_diff", {31'b0, coll}, 32'h0);
    rd(10'h100, ra, rb, ra2); chk("diff_a", ra, 32'h1001);
    rd(10'h101, ra, rb, ra2); chk("diff_b", rb, 32'h2002);

    // Same-address dual commit: A wins, collision sticky until init
    en_a = 1'b1; en_b = 1'b1; we_a = 1'b1; we_b = 1'b1;
    addr_a = 10'h3FF; din_a = 32'hAAAA_0000; addr_b = 10'h3FF; din_b = 32'h0000_BBBB;
    tick();
    en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    chk("coll_same", {31'b0, coll}, {31'b0, COLL_ON});
    chk("coll_same2", {31'b0, coll2}, {31'b0, COLL_ON});
    rd(10'h3FF, ra, rb, ra2);
    chk("awins_a", ra, 32'hAAAA_0000);
    chk("awins_b", rb, 32'hAAAA_0000);
    chk("coll_sticky", {31'b0, coll}, {31'b0, COLL_ON});
    init = 1'b1; tick(); init = 1'b0;
    chk("coll_init", {31'b0, coll}, 32'h0);

    // mem_sel substitutes for enable_a; without either no write
    wr_b(10'h050, 32'h50);
    wr_b(10'h051, 32'h51);
    en_a = 1'b0; mem_sel = 1'b1; we_a = 1'b1; addr_a = 10'h050; din_a = 32'h5E1;
    tick();
    mem_sel = 1'b0; addr_a = 10'h051; din_a = 32'hBAD;
    tick();
    we_a = 1'b0;
    rd(10'h050, ra, rb, ra2); chk("memsel_on", ra, 32'h5E1);
    rd(10'h051, ra, rb, ra2); chk("memsel_off", ra, 32'h51);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/siw_memory_bram_param.md
Name: siw_memory_bram_param

Overview:
Parametrised successor of the fixed 1024x32 dual-port BRAM wrapper: true dual-port memory with a registered read path and per-port programmable write-enable delay lines. Data width, depth and maximum write delay are parameters. Adds single-clock operation, same-address write-collision arbitration and clear-on-init of the delay lines. Sits between the datapath engines and the memory macro in the accelerator fabric.

Parameters:
DATA_W, 32, data width per port in bits
ADDR_W, 10, address width; depth = 2**ADDR_W words
MAX_DLY, 3, maximum write-enable delay in cycles (>=1)
CONF_W, 2, mem_conf width; must satisfy 2**CONF_W > MAX_DLY

Ports:
siw_memory_bram_param_clk  in  1  single clock for both ports
siw_memory_bram_param_reset_n  in  1  asynchronous active-low reset
siw_memory_bram_param_init  in  1  synchronous clear of both delay lines
siw_memory_bram_param_mem_sel  in  1  host-select; ORed into port A enable for writes
siw_memory_bram_param_enable_a / _enable_b  in  1  port enable
siw_memory_bram_param_write_en_a / _write_en_b  in  1  raw write request
siw_memory_bram_param_address_a / _address_b  in  ADDR_W  word address
siw_memory_bram_param_input_data_a / _input_data_b  in  DATA_W  write data
siw_memory_bram_param_mem_conf_a / _mem_conf_b  in  CONF_W  write-enable delay select
siw_memory_bram_param_output_data_a / _output_data_b  out  DATA_W  registered read data
siw_memory_bram_param_collision  out  1  sticky same-address write collision flag (optional)

Behaviour:
- Reset (reset_n=0, async): all delay-line stages 0, output data registers 0, collision 0. Memory contents not reset.
- Delay line per port: shift register of MAX_DLY stages; stage1 <= write_en, stageK <= stage(K-1). init=1 loads 0 into every stage on the next edge, overriding shifting.
- Effective write: wr_x = write_en_x if conf=0, else stage[conf]; conf > MAX_DLY saturates to stage[MAX_DLY].
- Commit A: wr_a & (enable_a | mem_sel). Commit B: wr_b & enable_b. Only the enable is delayed; address and data are sampled in the commit cycle.
- Read: memory read registered every cycle (no enable gating), then output register; address-to-output latency = 2 cycles.
- Same-port read-during-write: read-first (old data appears 2 cycles later).
- Cross-port write to X with other-port read of X in same cycle: reader gets old data.
- Both ports commit to the same address in the same cycle: port A wins, port B write dropped.
- Changing mem_conf mid-stream: takes effect immediately; in-flight stages are not flushed.
- Reset asserted mid-operation: delay lines cleared; pending delayed writes lost.

Optional Feature:
SIW_MEMORY_BRAM_PARAM_COLLISION_EN. Defined: collision is set on the edge after any same-address dual commit and cleared only by reset_n or init. Undefined: collision port tied to 0, comparator logic removed; A-wins arbitration still applies.

Decomposition:
- Package siw_memory_pkg: MEM_CONF_W, default widths/depths, conf encodings (CONF_NODLY=0).
- One sub-module: siw_tp_mem_2r2w, a generic parametrised dual-port array (DATA_W, ADDR_W), read-first, one clock, with arbitration done in the wrapper. The delay line stays inline.

Test Plan:
- Reset: reset_n=0 with junk inputs -> outputs 0, collision 0; release, read addr 5 -> data valid at cycle +2.
- conf_a=0, write 0xDEADBEEF @0x010 -> read @0x010 returns 0xDEADBEEF 2 cycles after read address.
- conf_a=2, write_en_a pulse at T, addr/data held at 0x020/0x1234 at T+2 -> memory written at T+2 only. conf_a=3 (MAX_DLY=3) -> T+3. conf=3 with MAX_DLY=2 -> saturates to T+2.
- init pulse 1 cycle after a conf=3 write request -> no write occurs; location keeps its old value.
- Both ports write @0x3FF, A=0xAAAA0000, B=0x0000BBBB -> read returns 0xAAAA0000; collision=1 (macro on) / 0 (macro off).
- enable_a=0, mem_sel=1, write_en_a=1 -> write commits; enable_a=0, mem_sel=0 -> no write.
